lsu_dm_master: RTL and testbench
================================

Name: lsu_dm_master

Overview:
- Load/store unit on the CPU side of the data memory port; acts as the initiator that drives mem_read, mem_write, address and write data into the big-endian, byte-addressed data memory.
- Accepts one load/store request at a time from the execute stage.
- Performs alignment checks, sign/zero extension for sub-word loads, and read-modify-write for SB/SH, since the memory port has no byte enables.
- Returns a single-cycle response.

Parameters:
- RD_LAT, 1: cycles from the first cycle mem_read is high until mem_data_read is valid (range 1-4).
- MEM_BYTES, 1024: memory size in bytes; any access touching a byte >= MEM_BYTES is an error.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; request accepted when req_valid && req_ready.
- req_op  in  3  operation code (package enum).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SB uses [7:0], SH uses [15:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range; valid with resp_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe, one cycle per write.
- mem_address  out  32  word-aligned byte address to memory (low 2 bits always 0).
- mem_data_write  out  32  word written to memory.
- mem_data_read  in  32  word from memory; byte at offset 0 is bits [31:24].

Behaviour:
- Clocking and reset:
  - One clock (clk); reset rst is asynchronous, active-high.
  - Reset forces state IDLE immediately.
  - Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_data_write=0, wait counter=0.
- States: IDLE, RD_WAIT, MERGE, WR, RESP.
- IDLE:
  - req_ready=1; all mem strobes 0.
  - On accept, latch op, addr and wdata.
  - Error if either holds:
    - misaligned: halfword ops with addr[0]=1; word ops with addr[1:0]!=0.
    - out of range: addr + size - 1 >= MEM_BYTES.
  - On error -> RESP with err=1; no mem strobe is ever asserted.
  - Loads and SB/SH -> RD_WAIT.
  - SW -> WR.
- RD_WAIT:
  - mem_read=1, mem_address={addr[31:2],2'b00}.
  - Counter runs 0..RD_LAT-1; on the RD_LAT-th cycle capture mem_data_read.
  - After capture, a load goes to RESP with extracted data; SB/SH go to MERGE.
- Load extraction (big-endian, off=addr[1:0]):
  - Byte lane = word[31-8*off -: 8].
  - Halfword = word[31-8*off -: 16], with off in {0,2}.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- MERGE: replace the addressed byte or halfword lane of the captured word with req_wdata[7:0] or [15:0]; other lanes unchanged -> WR.
- WR:
  - Exactly one cycle: mem_write=1, mem_address aligned, mem_data_write = merged word (SW: req_wdata).
  - mem_read=0 in WR; mem_read and mem_write are never both high.
  - -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle with resp_rdata/resp_err; req_ready=0.
  - -> IDLE.
  - No response back-pressure; the consumer must take it.
- Handshake and latency:
  - req_ready=0 in every state except IDLE.
  - Throughput: one request in flight.
  - Cycles from accept to resp_valid: load RD_LAT+1; SW 2; SB/SH RD_LAT+3; error 1.
- Boundary conditions:
  - Reset mid-RD_WAIT/MERGE: the write never occurs and memory is unchanged.
  - Reset coincident with WR: the write is not guaranteed; the bench must not rely on it.
  - req_valid held high in RESP: not accepted until IDLE on the next cycle.
  - Highest legal word address is MEM_BYTES-4 (0x3FC for the default); 0x3FD with LW is an error.

Decomposition:
- Package lsu_pkg:
  - op enum LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7.
  - State enum.
  - Helper functions is_store(op) and access_size(op).
- One sub-module: lsu_lane_align, purely combinational. Given word, offset and op, it produces the extended load data and the merged store word. It is shared by load extraction and MERGE.

Test Plan:
- Preload word 0x10 = 0x80817F02; RD_LAT=1 -> LB 0x10 returns 0xFFFFFF80; LBU 0x11 returns 0x00000081; LH 0x12 returns 0x00007F02. Each response arrives 2 cycles after accept.
- SB addr 0x13, wdata 0x123456AB -> one mem_read cycle, then one mem_write with data 0x80817FAB at address 0x10; a subsequent LW 0x10 returns 0x80817FAB.
- SW addr 0x3FC, data 0xDEADBEEF -> no mem_read; mem_write at 0x3FC; resp 2 cycles after accept, err=0.
- LW 0x12 and LH 0x3FF -> resp_err=1 one cycle after accept, resp_rdata=0; mem_read and mem_write stay 0 throughout.
- RD_LAT=3, SH addr 0x10, data 0xBEEF -> mem_read high 3 cycles; write 0xBEEF7F02; resp at accept+6.
- Assert rst during RD_WAIT of an SB to 0x13 -> outputs return to reset values immediately; no mem_write; word 0x10 unchanged; req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: opcodes, FSM states,
// and per-opcode access classification.
package lsu_pkg;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd3,
      LHU = 3'd4,
      SB  = 3'd5,
      SH  = 3'd6,
      SW  = 3'd7
   } op_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      MERGE   = 3'd2,
      WR      = 3'd3,
      RESP    = 3'd4
   } state_t;

   function automatic logic is_store(input op_t op);
      return (op == SB) || (op == SH) || (op == SW);
   endfunction

   // Number of bytes touched by the access.
   function automatic logic [2:0] access_size(input op_t op);
      unique case (op)
         LB, LBU, SB: return 3'd1;
         LH, LHU, SH: return 3'd2;
         default:     return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_dm_master_lane_align.sv
// Big-endian lane steering: extracts/extends load data from a memory word and
// builds the merged word for byte/halfword stores (the port has no byte enables).
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  op_t         op,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [4:0]  byte_shift;
   logic [4:0]  half_shift;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // Offset 0 is the most significant byte, so the shift is (3-off) bytes.
   assign byte_shift = {~off, 3'b000};
   assign half_shift = {~off[1], 4'b0000};
   assign byte_val   = 8'(word >> byte_shift);
   assign half_val   = 16'(word >> half_shift);

   always_comb begin
      load_data = 32'd0;
      unique case (op)
         LB:      load_data = {{24{byte_val[7]}}, byte_val};
         LBU:     load_data = {24'd0, byte_val};
         LH:      load_data = {{16{half_val[15]}}, half_val};
         LHU:     load_data = {16'd0, half_val};
         LW:      load_data = word;
         default: load_data = 32'd0;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic       hit;
         logic [7:0] src;

         always_comb begin
            hit = 1'b0;
            src = wdata[7:0];
            unique case (op)
               SB: hit = (off == LANE);
               SH: begin
                  hit = (off[1] == LANE[1]);
                  src = LANE[0] ? wdata[7:0] : wdata[15:8];
               end
               SW: begin
                  hit = 1'b1;
                  src = wdata[31-8*gi -: 8];
               end
               default: hit = 1'b0;
            endcase
         end

         assign merged[31-8*gi -: 8] = hit ? src : word[31-8*gi -: 8];
      end
   endgenerate

endmodule

// File: rtl/lsu_dm_master.sv
// Load/store unit driving a word-wide big-endian data memory: one request in
// flight, alignment/range checks, and read-modify-write for SB/SH.
module lsu_dm_master
   import lsu_pkg::*;
#(
   parameter int RD_LAT    = 1,
   parameter int MEM_BYTES = 1024
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  op_t         req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_write,
   input  logic [31:0] mem_data_read
);

   state_t      state, state_next;
   op_t         op_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [31:0] word_reg;
   logic [31:0] rdata_reg;
   logic [31:0] wr_word_reg;
   logic        err_reg;
   logic [2:0]  cnt_reg;

   logic [32:0] last_byte;
   logic        misaligned;
   logic        out_of_range;
   logic        req_err;
   logic        capture;
   logic [31:0] align_word;
   logic [31:0] load_data;
   logic [31:0] merged;

   // 33-bit sum so addresses near 2^32 cannot wrap into range.
   assign last_byte    = {1'b0, req_addr} + 33'(access_size(req_op)) - 33'd1;
   assign out_of_range = last_byte >= 33'(MEM_BYTES);

   always_comb begin
      misaligned = 1'b0;
      unique case (access_size(req_op))
         3'd2:    misaligned = req_addr[0];
         3'd4:    misaligned = |req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign req_err    = misaligned || out_of_range;
   assign capture    = (state == RD_WAIT) && (cnt_reg == 3'(RD_LAT - 1));
   assign align_word = (state == MERGE) ? word_reg : mem_data_read;

   lsu_lane_align u_align (
      .word      (align_word),
      .off       (addr_reg[1:0]),
      .op        (op_reg),
      .wdata     (wdata_reg),
      .load_data (load_data),
      .merged    (merged)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next     = state;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_err       = 1'b0;
      resp_rdata     = 32'd0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = 32'd0;
      mem_data_write = 32'd0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err)           state_next = RESP;
               else if (req_op == SW) state_next = WR;
               else                   state_next = RD_WAIT;
            end
         end
         RD_WAIT: begin
            mem_read    = 1'b1;
            mem_address = {addr_reg[31:2], 2'b00};
            if (capture) state_next = is_store(op_reg) ? MERGE : RESP;
         end
         MERGE: state_next = WR;
         WR: begin
            mem_write      = 1'b1;
            mem_address    = {addr_reg[31:2], 2'b00};
            mem_data_write = wr_word_reg;
            state_next     = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_reg;
            resp_rdata = rdata_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg      <= LB;
         addr_reg    <= 32'd0;
         wdata_reg   <= 32'd0;
         word_reg    <= 32'd0;
         rdata_reg   <= 32'd0;
         wr_word_reg <= 32'd0;
         err_reg     <= 1'b0;
         cnt_reg     <= 3'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  op_reg      <= req_op;
                  addr_reg    <= req_addr;
                  wdata_reg   <= req_wdata;
                  err_reg     <= req_err;
                  rdata_reg   <= 32'd0;
                  wr_word_reg <= req_wdata;
                  cnt_reg     <= 3'd0;
               end
            end
            RD_WAIT: begin
               if (capture) begin
                  cnt_reg  <= 3'd0;
                  word_reg <= mem_data_read;
                  if (!is_store(op_reg)) rdata_reg <= load_data;
               end else begin
                  cnt_reg <= cnt_reg + 3'd1;
               end
            end
            MERGE:   wr_word_reg <= merged;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dm_master.sv
// Directed bench for lsu_dm_master: two instances (RD_LAT=1 and RD_LAT=3),
// each with its own big-endian word memory model.
module tb_lsu_dm_master;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_valid[2], req_ready[2], resp_valid[2], resp_err[2];
   logic        mem_read[2], mem_write[2];
   op_t         req_op[2];
   logic [31:0] req_addr[2], req_wdata[2], resp_rdata[2];
   logic [31:0] mem_address[2], mem_data_write[2], mem_data_read[2];

   logic [31:0] mem[2][256];
   int          rd_run[2] = '{0, 0};
   int          n_rd[2]   = '{0, 0};
   int          n_wr[2]   = '{0, 0};
   int          n_viol[2] = '{0, 0};
   logic [31:0] last_waddr[2], last_wdata[2];

   int n_vec = 0;
   int n_bad = 0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         lsu_dm_master #(.RD_LAT(gi == 0 ? 1 : 3), .MEM_BYTES(1024)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .req_valid      (req_valid[gi]),
            .req_ready      (req_ready[gi]),
            .req_op         (req_op[gi]),
            .req_addr       (req_addr[gi]),
            .req_wdata      (req_wdata[gi]),
            .resp_valid     (resp_valid[gi]),
            .resp_rdata     (resp_rdata[gi]),
            .resp_err       (resp_err[gi]),
            .mem_read       (mem_read[gi]),
            .mem_write      (mem_write[gi]),
            .mem_address    (mem_address[gi]),
            .mem_data_write (mem_data_write[gi]),
            .mem_data_read  (mem_data_read[gi])
         );
      end
   endgenerate

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   // Read data is only valid on the RD_LAT-th mem_read cycle; garbage otherwise.
   always_comb begin
      for (int i = 0; i < 2; i++)
         mem_data_read[i] = (mem_read[i] && rd_run[i] == lat_of(i) - 1)
                            ? mem[i][mem_address[i][9:2]] : 32'hA5A5A5A5;
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         rd_run[i] <= mem_read[i] ? rd_run[i] + 1 : 0;
         if (mem_read[i]) n_rd[i] <= n_rd[i] + 1;
         if (mem_write[i]) begin
            n_wr[i]       <= n_wr[i] + 1;
            mem[i][mem_address[i][9:2]] <= mem_data_write[i];
            last_waddr[i] <= mem_address[i];
            last_wdata[i] <= mem_data_write[i];
         end
         if ((mem_read[i] && mem_write[i]) ||
             ((mem_read[i] || mem_write[i]) && mem_address[i][1:0] != 2'b00))
            n_viol[i] <= n_viol[i] + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      int          idx;
      op_t         op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          reads;
      int          writes;
      logic [31:0] waddr;
      logic [31:0] wword;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int idx, input op_t op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                      input int lat, input int reads, input int writes,
                      input logic [31:0] waddr, input logic [31:0] wword);
      vec_t v;
      v.idx = idx; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.err = err; v.lat = lat; v.reads = reads; v.writes = writes;
      v.waddr = waddr; v.wword = wword;
      vecs.push_back(v);
   endtask

   // Called at #1 after a rising edge with the target instance idle.
   task automatic run_vec(input int k, input vec_t v);
      int r0, w0, lat;
      int i;
      i  = v.idx;
      r0 = n_rd[i];
      w0 = n_wr[i];
      check($sformatf("v%0d ready_idle", k), 32'(req_ready[i]), 32'd1);
      req_valid[i] = 1'b1;
      req_op[i]    = v.op;
      req_addr[i]  = v.addr;
      req_wdata[i] = v.wdata;
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      lat = 1;
      while (!resp_valid[i] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      $display("txn %0d dut%0d %s addr=%h wdata=%h -> rdata=%h err=%b lat=%0d reads=%0d writes=%0d",
               k, i, v.op.name(), v.addr, v.wdata, resp_rdata[i], resp_err[i], lat,
               n_rd[i] - r0, n_wr[i] - w0);
      check($sformatf("v%0d latency", k), 32'(lat), 32'(v.lat));
      check($sformatf("v%0d rdata", k), resp_rdata[i], v.rdata);
      check($sformatf("v%0d err", k), 32'(resp_err[i]), 32'(v.err));
      check($sformatf("v%0d ready_in_resp", k), 32'(req_ready[i]), 32'd0);
      check($sformatf("v%0d reads", k), 32'(n_rd[i] - r0), 32'(v.reads));
      check($sformatf("v%0d writes", k), 32'(n_wr[i] - w0), 32'(v.writes));
      if (v.writes > 0) begin
         check($sformatf("v%0d waddr", k), last_waddr[i], v.waddr);
         check($sformatf("v%0d wword", k), last_wdata[i], v.wword);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d resp_one_cycle", k), 32'(resp_valid[i]), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag, input int i);
      check($sformatf("%s dut%0d req_ready", tag, i), 32'(req_ready[i]), 32'd1);
      check($sformatf("%s dut%0d resp_valid", tag, i), 32'(resp_valid[i]), 32'd0);
      check($sformatf("%s dut%0d resp_err", tag, i), 32'(resp_err[i]), 32'd0);
      check($sformatf("%s dut%0d resp_rdata", tag, i), resp_rdata[i], 32'd0);
      check($sformatf("%s dut%0d mem_read", tag, i), 32'(mem_read[i]), 32'd0);
      check($sformatf("%s dut%0d mem_write", tag, i), 32'(mem_write[i]), 32'd0);
      check($sformatf("%s dut%0d mem_address", tag, i), mem_address[i], 32'd0);
      check($sformatf("%s dut%0d mem_data_write", tag, i), mem_data_write[i], 32'd0);
   endtask

   initial begin
      int w0;
      vec_t v;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_op[i]    = LB;
         req_addr[i]  = 32'd0;
         req_wdata[i] = 32'd0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) check_reset_outputs("reset", i);
      rst = 1'b0;
      @(posedge clk); #1;

      // idx op addr wdata | rdata err lat reads writes waddr wword
      add(0, SW,  32'h10,  32'h80817F02, 32'h0,        0, 2, 0, 1, 32'h10,  32'h80817F02);
      add(0, LB,  32'h10,  32'h0,        32'hFFFFFF80, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, LBU, 32'h11,  32'h0,        32'h00000081, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, LH,  32'h12,  32'h0,        32'h00007F02, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, LHU, 32'h10,  32'h0,        32'h00008081, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, LH,  32'h10,  32'h0,        32'hFFFF8081, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, SB,  32'h13,  32'h123456AB, 32'h0,        0, 4, 1, 1, 32'h10,  32'h80817FAB);
      add(0, LW,  32'h10,  32'h0,        32'h80817FAB, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, SW,  32'h3FC, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 32'h3FC, 32'hDEADBEEF);
      add(0, LW,  32'h3FC, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, LB,  32'h3FF, 32'h0,        32'hFFFFFFEF, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, LBU, 32'h3FE, 32'h0,        32'h000000BE, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, LH,  32'h3FE, 32'h0,        32'hFFFFBEEF, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, SB,  32'h11,  32'h00000055, 32'h0,        0, 4, 1, 1, 32'h10,  32'h80557FAB);
      add(0, LW,  32'h10,  32'h0,        32'h80557FAB, 0, 2, 1, 0, 32'h0,   32'h0);
      add(0, LW,  32'h12,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0,   32'h0);
      add(0, LH,  32'h3FF, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,   32'h0);
      add(0, LW,  32'h3FD, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,   32'h0);
      add(0, LB,  32'h400, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,   32'h0);
      add(0, SH,  32'h400, 32'h1234,     32'h0,        1, 1, 0, 0, 32'h0,   32'h0);
      add(0, SW,  32'h3FE, 32'h1234,     32'h0,        1, 1, 0, 0, 32'h0,   32'h0);
      add(0, LHU, 32'hFFFFFFFE, 32'h0,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0);
      add(1, SW,  32'h10,  32'h80817F02, 32'h0,        0, 2, 0, 1, 32'h10,  32'h80817F02);
      add(1, SH,  32'h10,  32'h0000BEEF, 32'h0,        0, 6, 3, 1, 32'h10,  32'hBEEF7F02);
      add(1, LW,  32'h10,  32'h0,        32'hBEEF7F02, 0, 4, 3, 0, 32'h0,   32'h0);
      add(1, LB,  32'h13,  32'h0,        32'h00000002, 0, 4, 3, 0, 32'h0,   32'h0);
      add(1, LHU, 32'h12,  32'h0,        32'h00007F02, 0, 4, 3, 0, 32'h0,   32'h0);

      for (int k = 0; k < vecs.size(); k++) begin
         v = vecs[k];
         run_vec(k, v);
      end

      // req_valid held high through RESP: second request only taken from IDLE.
      req_valid[0] = 1'b1;
      req_op[0]    = LW;
      req_addr[0]  = 32'h3FC;
      @(posedge clk); #1;
      check("hold rd_wait1 mem_read", 32'(mem_read[0]), 32'd1);
      @(posedge clk); #1;
      check("hold resp1 valid", 32'(resp_valid[0]), 32'd1);
      check("hold resp1 ready", 32'(req_ready[0]), 32'd0);
      check("hold resp1 rdata", resp_rdata[0], 32'hDEADBEEF);
      @(posedge clk); #1;
      check("hold idle ready", 32'(req_ready[0]), 32'd1);
      check("hold idle mem_read", 32'(mem_read[0]), 32'd0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      check("hold rd_wait2 mem_read", 32'(mem_read[0]), 32'd1);
      @(posedge clk); #1;
      check("hold resp2 valid", 32'(resp_valid[0]), 32'd1);
      check("hold resp2 rdata", resp_rdata[0], 32'hDEADBEEF);
      $display("txn hold dut0 LW addr=000003fc back-to-back -> rdata=%h", resp_rdata[0]);
      @(posedge clk); #1;

      // Reset in the middle of an SB read phase must abort the write.
      w0 = n_wr[1];
      req_valid[1] = 1'b1;
      req_op[1]    = SB;
      req_addr[1]  = 32'h13;
      req_wdata[1] = 32'h00000011;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      check("rstmid mem_read", 32'(mem_read[1]), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("rstmid", 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("rstmid no write", 32'(n_wr[1] - w0), 32'd0);
      check("rstmid word", mem[1][4], 32'hBEEF7F02);
      check("rstmid ready", 32'(req_ready[1]), 32'd1);
      $display("txn rstmid dut1 SB addr=00000013 aborted, writes=%0d word=%h", n_wr[1] - w0, mem[1][4]);
      add(1, LW, 32'h10, 32'h0, 32'hBEEF7F02, 0, 4, 3, 0, 32'h0, 32'h0);
      v = vecs[vecs.size() - 1];
      run_vec(vecs.size() - 1, v);

      for (int i = 0; i < 2; i++)
         check($sformatf("dut%0d strobe/alignment violations", i), 32'(n_viol[i]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
